osc_capture_ctrl: RTL and testbench

Acquisition front-end of the oscilloscope datapath. Takes the ADC sample stream, detects a level/edge trigger, and writes a pre-/post-trigger frame into the write half of the ping-pong BRAM pair. The outputs `addrWR`, `DI`, `WE` and `addrSel` drive the ping-pong buffer directly. A completed frame is handed to the display reader by toggling `addrSel` and pulsing `frame_ready`.

---
 rtl/osc_pkg.sv | 30 +++
 rtl/osc_trig_detect.sv | 53 +++++
 rtl/osc_capture_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_osc_capture_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/osc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : osc_pkg
//  Description : Shared types and constants for the oscilloscope capture path.
//                Holds the capture FSM state encoding, the trigger-edge
//                encoding and a small state-classification helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package osc_pkg;

    // Capture FSM states
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PREFILL   = 3'd1,
        WAIT_TRIG = 3'd2,
        POSTFILL  = 3'd3,
        HOLD      = 3'd4
    } state_t;

    // Trigger edge selection encoding
    localparam logic TRIG_RISE = 1'b0;
    localparam logic TRIG_FALL = 1'b1;

    // States in which incoming ADC samples are written to the BRAM
    function automatic logic is_capture_state(input state_t s);
        return (s == PREFILL) || (s == WAIT_TRIG) || (s == POSTFILL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/osc_trig_detect.sv
`default_nettype none
// ============================================================================
//  Module      : osc_trig_detect
//  Description : Level/edge trigger detector. Remembers the previously
//                accepted sample and flags a crossing of the threshold in
//                the selected direction by the current sample.
//  Revision    : 1.0 - initial release
// ============================================================================
module osc_trig_detect
    import osc_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_accept,
    input  logic [DATA_W-1:0] i_sample,
    input  logic [DATA_W-1:0] i_level,
    input  logic              i_edge,
    output logic              o_trig_hit
);

    logic [DATA_W-1:0] r_prev;
    logic              r_prev_valid;
    logic              w_rise;
    logic              w_fall;

    // Track the previous accepted sample; forget it between frames
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
        end else if (i_clear) begin
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
        end else if (i_accept) begin
            r_prev       <= i_sample;
            r_prev_valid <= 1'b1;
        end
    end

    // Threshold crossings; the first sample of a frame has no history
    always_comb begin
        w_rise     = (r_prev <  i_level) && (i_sample >= i_level);
        w_fall     = (r_prev >= i_level) && (i_sample <  i_level);
        o_trig_hit = r_prev_valid &&
                     (((i_edge == TRIG_RISE) && w_rise) ||
                      ((i_edge == TRIG_FALL) && w_fall));
    end

endmodule
`default_nettype wire

// File: rtl/osc_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : osc_capture_ctrl
//  Description : Oscilloscope acquisition front-end. Writes a pre/post
//                trigger frame into the write half of a ping-pong BRAM and
//                hands finished frames to the reader by toggling addrSel
//                and pulsing frame_ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module osc_capture_ctrl
    import osc_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 11,
    parameter int PRETRIG = 512,
    parameter int AUTO_TO = 65535
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              run,
    input  logic              auto_mode,
    input  logic              trig_edge,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    input  logic              bank_free,
    output logic [ADDR_W-1:0] addrWR,
    output logic [DATA_W-1:0] DI,
    output logic              WE,
    output logic              addrSel,
    output logic              frame_ready,
    output logic [ADDR_W-1:0] frame_start,
    output logic              forced
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = ADDR_W + 1;
    localparam int TO_W  = (AUTO_TO > 1) ? $clog2(AUTO_TO) : 1;

    // Last pre-trigger index, last post-trigger index, timeout terminal count
    localparam logic [CNT_W-1:0]  c_PRE_LAST   = CNT_W'(PRETRIG - 1);
    localparam logic [CNT_W-1:0]  c_POST_LAST  = CNT_W'(DEPTH - PRETRIG - 1);
    localparam logic [ADDR_W-1:0] c_PRETRIG_A  = ADDR_W'(PRETRIG);
    localparam logic [TO_W-1:0]   c_TO_LAST    = TO_W'(AUTO_TO - 1);
    // A frame with a single post-trigger sample finishes on the trigger itself
    localparam state_t            c_AFTER_TRIG = (DEPTH - PRETRIG == 1) ? HOLD : POSTFILL;

    state_t            r_state;
    logic [ADDR_W-1:0] r_wptr;
    logic [CNT_W-1:0]  r_cnt;
    logic [TO_W-1:0]   r_to_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_di;
    logic              r_we;
    logic              r_sel;
    logic              r_fr;
    logic [ADDR_W-1:0] r_fstart;
    logic              r_forced;
    logic [ADDR_W-1:0] r_trig_start;
    logic              r_trig_forced;

    logic w_accept;
    logic w_clear;
    logic w_trig_hit;
    logic w_timeout;
    logic w_trigger;

    // Sample acceptance, history reset and trigger qualification
    always_comb begin
        w_accept  = run && sample_valid && is_capture_state(r_state);
        w_clear   = (r_state == IDLE) || (r_state == HOLD);
        w_timeout = auto_mode && (r_to_cnt == c_TO_LAST);
        w_trigger = w_trig_hit || w_timeout;
    end

    osc_trig_detect #(
        .DATA_W (DATA_W)
    ) u_trig_detect (
        .clk        (CLK),
        .rst_n      (RST),
        .i_clear    (w_clear),
        .i_accept   (w_accept),
        .i_sample   (sample_data),
        .i_level    (trig_level),
        .i_edge     (trig_edge),
        .o_trig_hit (w_trig_hit)
    );

    // Capture FSM, counters and registered BRAM-side outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state       <= IDLE;
            r_wptr        <= '0;
            r_cnt         <= '0;
            r_to_cnt      <= '0;
            r_addr        <= '0;
            r_di          <= '0;
            r_we          <= 1'b0;
            r_sel         <= 1'b0;
            r_fr          <= 1'b0;
            r_fstart      <= '0;
            r_forced      <= 1'b0;
            r_trig_start  <= '0;
            r_trig_forced <= 1'b0;
        end else begin
            r_we <= 1'b0;
            r_fr <= 1'b0;

            // Every accepted sample is written at the running pointer
            if (w_accept) begin
                r_we   <= 1'b1;
                r_addr <= r_wptr;
                r_di   <= sample_data;
                r_wptr <= r_wptr + 1'b1;
            end

            if (!run) begin
                // Abort: partial frame is discarded, bank ownership unchanged
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= PREFILL;
                        r_wptr  <= '0;
                        r_cnt   <= '0;
                    end

                    PREFILL: begin
                        if (sample_valid) begin
                            if (r_cnt == c_PRE_LAST) begin
                                r_state  <= WAIT_TRIG;
                                r_cnt    <= '0;
                                r_to_cnt <= '0;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end

                    WAIT_TRIG: begin
                        if (sample_valid) begin
                            if (w_trigger) begin
                                // Trigger sample is the first post-trigger sample
                                r_trig_start  <= r_wptr - c_PRETRIG_A;
                                r_trig_forced <= !w_trig_hit;
                                r_cnt         <= CNT_W'(1);
                                r_state       <= c_AFTER_TRIG;
                            end else if (r_to_cnt != c_TO_LAST) begin
                                // Saturate so a late auto_mode enable fires at once
                                r_to_cnt <= r_to_cnt + 1'b1;
                            end
                        end
                    end

                    POSTFILL: begin
                        if (sample_valid) begin
                            if (r_cnt == c_POST_LAST) begin
                                r_state <= HOLD;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end

                    HOLD: begin
                        if (bank_free) begin
                            r_sel    <= ~r_sel;
                            r_fr     <= 1'b1;
                            r_fstart <= r_trig_start;
                            r_forced <= r_trig_forced;
                            r_state  <= PREFILL;
                            r_wptr   <= '0;
                            r_cnt    <= '0;
                        end
                    end

                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign addrWR      = r_addr;
    assign DI          = r_di;
    assign WE          = r_we;
    assign addrSel     = r_sel;
    assign frame_ready = r_fr;
    assign frame_start = r_fstart;
    assign forced      = r_forced;

endmodule
`default_nettype wire

// File: tb/tb_osc_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_osc_capture_ctrl
//  Description : Scoreboard testbench for osc_capture_ctrl with a 16-deep
//                bank, 4 pre-trigger samples and an 8-sample auto timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_osc_capture_ctrl;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 4;
    localparam int PRETRIG = 4;
    localparam int AUTO_TO = 8;
    localparam int POST    = (2 ** ADDR_W) - PRETRIG;

    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic              run = 1'b0;
    logic              auto_mode = 1'b0;
    logic              trig_edge = 1'b0;
    logic [DATA_W-1:0] trig_level = 8'd10;
    logic              sample_valid = 1'b0;
    logic [DATA_W-1:0] sample_data = '0;
    logic              bank_free = 1'b1;
    logic [ADDR_W-1:0] addrWR;
    logic [DATA_W-1:0] DI;
    logic              WE;
    logic              addrSel;
    logic              frame_ready;
    logic [ADDR_W-1:0] frame_start;
    logic              forced;

    typedef struct {
        bit         we;
        logic [3:0] addr;
        logic [7:0] data;
        bit         fr;
        logic [3:0] fs;
        bit         frc;
        bit         sel;
    } exp_t;

    exp_t       q[$];
    exp_t       mon_e;
    logic [7:0] data_buf [64];
    bit         exp_sel    = 1'b0;
    logic [3:0] exp_fs     = '0;
    bit         exp_forced = 1'b0;
    int         n_tests    = 0;
    int         n_fail     = 0;

    osc_capture_ctrl #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .PRETRIG (PRETRIG),
        .AUTO_TO (AUTO_TO)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .run          (run),
        .auto_mode    (auto_mode),
        .trig_edge    (trig_edge),
        .trig_level   (trig_level),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .bank_free    (bank_free),
        .addrWR       (addrWR),
        .DI           (DI),
        .WE           (WE),
        .addrSel      (addrSel),
        .frame_ready  (frame_ready),
        .frame_start  (frame_start),
        .forced       (forced)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One stimulus cycle: drive inputs on the falling edge and queue what the
    // outputs must look like after the following rising edge.
    task automatic cyc(input bit r, input bit bf, input bit v, input logic [7:0] d,
                       input bit we, input logic [3:0] a, input bit fr);
        exp_t e;
        @(negedge CLK);
        run          = r;
        bank_free    = bf;
        sample_valid = v;
        sample_data  = d;
        e.we   = we;
        e.addr = a;
        e.data = d;
        e.fr   = fr;
        e.fs   = exp_fs;
        e.frc  = exp_forced;
        e.sel  = exp_sel;
        q.push_back(e);
    endtask

    // Full frame from PREFILL entry: trigger at sample index t, POST writes
    // starting with the trigger, then 'hold' cycles with the reader busy and
    // one handover cycle in which the arriving sample is dropped.
    task automatic run_frame(input int t, input bit frc, input int hold);
        for (int k = 0; k <= t + POST + hold; k++) begin
            bit fr;
            fr = (k == t + POST + hold);
            if (fr) begin
                exp_sel    = ~exp_sel;
                exp_fs     = 4'(t - PRETRIG);
                exp_forced = frc;
            end
            cyc(1'b1, (hold == 0) || fr, 1'b1, data_buf[k], k < t + POST, 4'(k), fr);
        end
    endtask

    // Scoreboard: compare the registered outputs just after each rising edge
    always @(posedge CLK) begin
        #1;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            check("WE", WE, mon_e.we);
            check("addrSel", addrSel, mon_e.sel);
            check("frame_ready", frame_ready, mon_e.fr);
            if (mon_e.we) begin
                check("addrWR", addrWR, mon_e.addr);
                check("DI", DI, mon_e.data);
            end
            if (mon_e.fr) begin
                check("frame_start", frame_start, mon_e.fs);
                check("forced", forced, mon_e.frc);
            end
        end
    end

    initial begin
        // Reset values
        #25;
        check("rst_addrWR", addrWR, 0);
        check("rst_DI", DI, 0);
        check("rst_WE", WE, 0);
        check("rst_addrSel", addrSel, 0);
        check("rst_frame_ready", frame_ready, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_forced", forced, 0);
        #2 RST = 1'b1;

        // Rising ramp: trigger on sample 10 at address 10
        for (int i = 0; i < 64; i++) data_buf[i] = 8'(i);
        cyc(1'b1, 1'b1, 1'b1, 8'd0, 1'b0, 4'd0, 1'b0);
        run_frame(10, 1'b0, 0);

        // Falling edge: 20,20,20,20,20,5 triggers at address 5
        trig_edge = 1'b1;
        for (int i = 0; i < 64; i++) data_buf[i] = (i < 5) ? 8'd20 : 8'd5;
        run_frame(5, 1'b0, 0);

        // Auto trigger on the 8th WAIT_TRIG sample of a flat input
        trig_edge = 1'b0;
        auto_mode = 1'b1;
        for (int i = 0; i < 64; i++) data_buf[i] = 8'd3;
        run_frame(PRETRIG + AUTO_TO - 1, 1'b1, 0);

        // Real trigger on the timeout sample wins over the timeout
        for (int i = 0; i < 64; i++) data_buf[i] = (i < PRETRIG + AUTO_TO - 1) ? 8'd3 : 8'd20;
        run_frame(PRETRIG + AUTO_TO - 1, 1'b0, 0);

        // No auto trigger: stays in WAIT_TRIG until a real edge at sample 30,
        // then the reader holds the bank for 20 cycles
        auto_mode = 1'b0;
        for (int i = 0; i < 64; i++) data_buf[i] = (i < 30) ? 8'd3 : 8'd20;
        run_frame(30, 1'b0, 20);

        // run dropped mid-POSTFILL, then restarted
        for (int i = 0; i < 64; i++) data_buf[i] = 8'(i);
        for (int k = 0; k <= 12; k++)
            cyc(1'b1, 1'b1, 1'b1, data_buf[k], 1'b1, 4'(k), 1'b0);
        for (int k = 0; k < 4; k++)
            cyc(1'b0, 1'b1, 1'b1, 8'(13 + k), 1'b0, 4'd0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 8'd0, 1'b0, 4'd0, 1'b0);
        run_frame(10, 1'b0, 0);

        // Asynchronous reset pulse during WAIT_TRIG
        for (int k = 0; k <= 6; k++)
            cyc(1'b1, 1'b1, 1'b1, 8'd3, 1'b1, 4'(k), 1'b0);
        @(posedge CLK);
        #2 RST = 1'b0;
        #1;
        check("arst_addrWR", addrWR, 0);
        check("arst_DI", DI, 0);
        check("arst_WE", WE, 0);
        check("arst_addrSel", addrSel, 0);
        check("arst_frame_ready", frame_ready, 0);
        check("arst_frame_start", frame_start, 0);
        check("arst_forced", forced, 0);
        #1 RST = 1'b1;
        exp_sel    = 1'b0;
        exp_fs     = '0;
        exp_forced = 1'b0;
        cyc(1'b1, 1'b1, 1'b1, 8'd0, 1'b0, 4'd0, 1'b0);
        run_frame(10, 1'b0, 0);

        // No write in the cycle after sample_valid drops
        cyc(1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 4'd0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 4'd0, 1'b0);
        @(posedge CLK);
        #3;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
